// File: rtl/controller_8085_multi_if.sv
// Control bus between the 8085-subset multi-cycle controller and its datapath.
// Carries the instruction-register fields, the live flags and the memory ready
// handshake toward the controller. It carries every enable, strobe and status
// bit back toward the datapath.
//   master : controller side (drives enables/strobes, samples IR fields/flags)
//   slave  : datapath side   (drives IR fields/flags/mem_ready, samples enables)
interface controller_8085_multi_if;
    logic [4:0] opcode;
    logic [4:0] funct;
    logic       z;
    logic       cy;
    logic       mem_ready;
    logic       irwrite;
    logic       iord;
    logic       read;
    logic       write;
    logic       pcwrite;
    logic [1:0] pcsrc;
    logic       regwrite;
    logic       accwrite;
    logic       cywrite;
    logic       zwrite;
    logic       cinsrc;
    logic       halted;
    logic       err;

    modport master (
        input  opcode, funct, z, cy, mem_ready,
        output irwrite, iord, read, write, pcwrite, pcsrc,
               regwrite, accwrite, cywrite, zwrite, cinsrc, halted, err
    );

    modport slave (
        output opcode, funct, z, cy, mem_ready,
        input  irwrite, iord, read, write, pcwrite, pcsrc,
               regwrite, accwrite, cywrite, zwrite, cinsrc, halted, err
    );
endinterface

// File: rtl/controller_8085_multi.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the 8085-subset core.
// Instruction fetch and data traffic share one memory port, and that port uses a
// ready handshake. A wait counter bounds every memory wait. When the bound
// expires, the sticky err flag is set and the controller parks in HALT.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset; it also forces every output to its reset value
//   bus  : controller_8085_multi_if.master (IR fields, flags, mem_ready in;
//          irwrite/iord/read/write/pcwrite/pcsrc/regwrite/accwrite/cywrite/
//          zwrite/cinsrc/halted/err out)
// Encoding map used by the classifier:
//   op 0,1 reg ALU / op 2 ALU with M, by funct: add0 adc1 sub2 sbb3 ana4 ora5
//     xra6 inr7 dcr8 cmp9
//   op 5..12 immediates: adi aci sui sbi ani ori xri cpi
//   op 4 by funct: nop0 cma1 cmc2 stc3 ret13 hlt14
//   loads 13 lda, 20 mov a,m, 23 mov r,m, 26 ldax; stores 14 sta, 22 mov m,r, 27 stax
//   15 jmp, 16 jnz, 17 jnc, 18 call; moves 19,21,28 -> reg; 24,25 -> acc
module controller_8085_multi #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    controller_8085_multi_if.master bus
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
        S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
    } state_t;

    // C_WRV: instruction whose only effect is the write vector (ALU ops and moves)
    typedef enum logic [3:0] {
        C_UNK = 4'd0, C_WRV = 4'd1, C_JMP = 4'd2, C_JNZ = 4'd3, C_JNC = 4'd4,
        C_CALL = 4'd5, C_RET = 4'd6, C_NOP = 4'd7, C_LOAD = 4'd8,
        C_STORE = 4'd9, C_HLT = 4'd10
    } class_t;

    state_t        state_r, state_n_s;
    class_t        cls_s;
    logic [CW-1:0] cnt_r, cnt_inc_s;
    logic          err_r;
    logic          aw_s, rw_s, cw_s, zw_s, cin_s;
    logic          wait_s, timeout_s;
    logic          irwrite_s, iord_s, read_s, write_s, pcwrite_s;
    logic [1:0]    pcsrc_s;
    logic          regwrite_s, accwrite_s, cywrite_s, zwrite_s, cinsrc_s;

    assign cnt_inc_s = cnt_r + CW'(1);

    // Instruction classifier: class plus the write vector applied in EXEC (or in WB for loads)
    always_comb begin
        cls_s = C_UNK;
        aw_s  = 1'b0; rw_s = 1'b0; cw_s = 1'b0; zw_s = 1'b0; cin_s = 1'b0;
        case (bus.opcode)
            5'd0, 5'd1, 5'd2: begin
                cls_s = (bus.opcode == 5'd2) ? C_LOAD : C_WRV;
                case (bus.funct)
                    5'd0, 5'd2, 5'd4, 5'd5, 5'd6: begin aw_s = 1'b1; cw_s = 1'b1; zw_s = 1'b1; end
                    5'd1, 5'd3: begin aw_s = 1'b1; cw_s = 1'b1; zw_s = 1'b1; cin_s = 1'b1; end
                    5'd7, 5'd8: begin rw_s = 1'b1; zw_s = 1'b1; end
                    5'd9:       begin cw_s = 1'b1; zw_s = 1'b1; end
                    default:    cls_s = C_UNK;
                endcase
            end
            5'd5, 5'd7, 5'd9, 5'd10, 5'd11: begin
                cls_s = C_WRV; aw_s = 1'b1; cw_s = 1'b1; zw_s = 1'b1;
            end
            5'd6, 5'd8: begin
                cls_s = C_WRV; aw_s = 1'b1; cw_s = 1'b1; zw_s = 1'b1; cin_s = 1'b1;
            end
            5'd12: begin cls_s = C_WRV; cw_s = 1'b1; zw_s = 1'b1; end
            5'd4: begin
                case (bus.funct)
                    5'd0:       cls_s = C_NOP;
                    5'd1:       begin cls_s = C_WRV; aw_s = 1'b1; end
                    5'd2, 5'd3: begin cls_s = C_WRV; cw_s = 1'b1; end
                    5'd13:      cls_s = C_RET;
                    5'd14:      cls_s = C_HLT;
                    default:    cls_s = C_UNK;
                endcase
            end
            5'd13, 5'd20, 5'd26: begin cls_s = C_LOAD; aw_s = 1'b1; end
            5'd23:               begin cls_s = C_LOAD; rw_s = 1'b1; end
            5'd14, 5'd22, 5'd27: cls_s = C_STORE;
            5'd15:               cls_s = C_JMP;
            5'd16:               cls_s = C_JNZ;
            5'd17:               cls_s = C_JNC;
            5'd18:               cls_s = C_CALL;
            5'd19, 5'd21, 5'd28: begin cls_s = C_WRV; rw_s = 1'b1; end
            5'd24, 5'd25:        begin cls_s = C_WRV; aw_s = 1'b1; end
            default:             cls_s = C_UNK;
        endcase
    end

    // Next-state and Moore output decode; FETCH/MEM also react to mem_ready in the same cycle
    always_comb begin
        state_n_s  = state_r;
        irwrite_s  = 1'b0; iord_s = 1'b0; read_s = 1'b0; write_s = 1'b0;
        pcwrite_s  = 1'b0; pcsrc_s = 2'b00;
        regwrite_s = 1'b0; accwrite_s = 1'b0; cywrite_s = 1'b0; zwrite_s = 1'b0; cinsrc_s = 1'b0;
        wait_s     = 1'b0; timeout_s = 1'b0;
        case (state_r)
            S_FETCH: begin
                read_s = 1'b1;
                if (bus.mem_ready) begin
                    irwrite_s = 1'b1; pcwrite_s = 1'b1; state_n_s = S_DECODE;
                end else if (cnt_inc_s == CW'(MEM_TIMEOUT)) begin
                    timeout_s = 1'b1; state_n_s = S_HALT;
                end else begin
                    wait_s = 1'b1;
                end
            end
            S_DECODE: begin
                if (cls_s == C_HLT) begin
                    state_n_s = S_HALT;
                end else if (cls_s == C_UNK) begin
                    state_n_s = S_FETCH;
                end else begin
                    state_n_s = S_EXEC;
                end
            end
            S_EXEC: begin
                state_n_s = S_FETCH;
                case (cls_s)
                    C_WRV: begin
                        accwrite_s = aw_s; regwrite_s = rw_s; cywrite_s = cw_s;
                        zwrite_s = zw_s; cinsrc_s = cin_s;
                    end
                    C_JMP:  begin pcwrite_s = 1'b1; pcsrc_s = 2'b01; end
                    C_JNZ:  begin pcwrite_s = ~bus.z;  pcsrc_s = bus.z  ? 2'b00 : 2'b01; end
                    C_JNC:  begin pcwrite_s = ~bus.cy; pcsrc_s = bus.cy ? 2'b00 : 2'b01; end
                    C_CALL: begin pcwrite_s = 1'b1; pcsrc_s = 2'b01; regwrite_s = 1'b1; end
                    C_RET:  begin pcwrite_s = 1'b1; pcsrc_s = 2'b10; end
                    C_LOAD, C_STORE: begin iord_s = 1'b1; state_n_s = S_MEM; end
                    default: state_n_s = S_FETCH;
                endcase
            end
            S_MEM: begin
                iord_s  = 1'b1;
                read_s  = (cls_s == C_LOAD);
                write_s = (cls_s == C_STORE);
                if (bus.mem_ready) begin
                    state_n_s = (cls_s == C_LOAD) ? S_WB : S_FETCH;
                end else if (cnt_inc_s == CW'(MEM_TIMEOUT)) begin
                    timeout_s = 1'b1; state_n_s = S_HALT;
                end else begin
                    wait_s = 1'b1;
                end
            end
            S_WB: begin
                accwrite_s = aw_s; regwrite_s = rw_s; cywrite_s = cw_s;
                zwrite_s = zw_s; cinsrc_s = cin_s;
                state_n_s = S_FETCH;
            end
            S_HALT:  state_n_s = S_HALT;
            default: state_n_s = S_FETCH;
        endcase
    end

    // State, wait counter and sticky timeout flag; the counter only survives an unanswered wait cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
            cnt_r   <= {CW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= wait_s ? cnt_inc_s : {CW{1'b0}};
            err_r   <= err_r | timeout_s;
        end
    end

    // rst is asserted in the same cycle as an in-flight strobe, so outputs are gated with it
    assign bus.irwrite  = irwrite_s  & ~rst;
    assign bus.iord     = iord_s     & ~rst;
    assign bus.read     = read_s     & ~rst;
    assign bus.write    = write_s    & ~rst;
    assign bus.pcwrite  = pcwrite_s  & ~rst;
    assign bus.pcsrc    = rst ? 2'b00 : pcsrc_s;
    assign bus.regwrite = regwrite_s & ~rst;
    assign bus.accwrite = accwrite_s & ~rst;
    assign bus.cywrite  = cywrite_s  & ~rst;
    assign bus.zwrite   = zwrite_s   & ~rst;
    assign bus.cinsrc   = cinsrc_s   & ~rst;
    assign bus.halted   = (state_r == S_HALT) & ~rst;
    assign bus.err      = err_r & ~rst;
endmodule

// File: tb/tb_controller_8085_multi.sv
// Self-checking bench for controller_8085_multi. A table of single instructions
// is checked cycle by cycle through FETCH/DECODE/EXEC and, where present,
// MEM/WB. Hand-written sequences then cover reset mid-store, a delayed load,
// the wait-counter boundary and timeout, an unknown opcode, and hlt.
// Output word layout: {err, irwrite, iord, read, write, pcwrite, pcsrc[1:0],
//                      regwrite, accwrite, cywrite, zwrite, cinsrc, halted}
module tb_controller_8085_multi;
    localparam logic [13:0] ERR    = 14'h2000;
    localparam logic [13:0] IRW    = 14'h1000;
    localparam logic [13:0] IORD   = 14'h0800;
    localparam logic [13:0] RD     = 14'h0400;
    localparam logic [13:0] WR     = 14'h0200;
    localparam logic [13:0] PCW    = 14'h0100;
    localparam logic [13:0] PC_RET = 14'h0080;
    localparam logic [13:0] PC_BR  = 14'h0040;
    localparam logic [13:0] RW     = 14'h0020;
    localparam logic [13:0] AW     = 14'h0010;
    localparam logic [13:0] CWR    = 14'h0008;
    localparam logic [13:0] ZW     = 14'h0004;
    localparam logic [13:0] CIN    = 14'h0002;
    localparam logic [13:0] HLT    = 14'h0001;
    localparam logic [13:0] NONE   = 14'h0000;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  fn;
        logic        z;
        logic        cy;
        logic [13:0] ex;
        logic        mem;
        logic [13:0] mx;
        logic        wb;
        logic [13:0] wx;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];

    controller_8085_multi_if bus ();

    controller_8085_multi #(.MEM_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] obs();
        return {bus.err, bus.irwrite, bus.iord, bus.read, bus.write, bus.pcwrite, bus.pcsrc,
                bus.regwrite, bus.accwrite, bus.cywrite, bus.zwrite, bus.cinsrc, bus.halted};
    endfunction

    task automatic chk(input string nm, input logic [13:0] exp);
        logic [13:0] act;
        act = obs();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] op, input logic [4:0] fn, input logic z, input logic cy,
                       input logic [13:0] ex, input logic mem, input logic [13:0] mx,
                       input logic wb, input logic [13:0] wx);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.cy = cy; v.ex = ex;
        v.mem = mem; v.mx = mx; v.wb = wb; v.wx = wx;
        vecs.push_back(v);
    endtask

    // One cycle: inputs change at the falling edge, outputs are sampled 1 time unit later
    task automatic step(input logic rdy);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
    endtask

    // FETCH cycle with the memory answering at once; the new IR fields appear with it
    task automatic fetch_op(input string nm, input logic [4:0] op, input logic [4:0] fn,
                            input logic z, input logic cy);
        @(negedge clk);
        rst = 1'b0;
        bus.opcode = op; bus.funct = fn; bus.z = z; bus.cy = cy;
        bus.mem_ready = 1'b1;
        #1;
        chk({nm, "_fetch"}, IRW | RD | PCW);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        fetch_op(tag, v.op, v.fn, v.z, v.cy);
        step(1'b0); chk({tag, "_decode"}, NONE);
        step(1'b0); chk({tag, "_exec"}, v.ex);
        if (v.mem) begin
            step(1'b1); chk({tag, "_mem"}, v.mx);
            if (v.wb) begin
                step(1'b0); chk({tag, "_wb"}, v.wx);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        bus.opcode = 5'd0; bus.funct = 5'd0; bus.z = 1'b0; bus.cy = 1'b0; bus.mem_ready = 1'b0;

        // op, fn, z, cy, exec, mem?, mem outputs, wb?, wb outputs
        add(5'd0,  5'd0,  1'b0, 1'b0, AW | CWR | ZW,       1'b0, NONE, 1'b0, NONE);  // add
        add(5'd0,  5'd1,  1'b0, 1'b0, AW | CWR | ZW | CIN, 1'b0, NONE, 1'b0, NONE);  // adc
        add(5'd0,  5'd9,  1'b0, 1'b0, CWR | ZW,            1'b0, NONE, 1'b0, NONE);  // cmp
        add(5'd0,  5'd7,  1'b0, 1'b0, RW | ZW,             1'b0, NONE, 1'b0, NONE);  // inr
        add(5'd6,  5'd0,  1'b0, 1'b0, AW | CWR | ZW | CIN, 1'b0, NONE, 1'b0, NONE);  // aci
        add(5'd12, 5'd0,  1'b0, 1'b0, CWR | ZW,            1'b0, NONE, 1'b0, NONE);  // cpi
        add(5'd4,  5'd1,  1'b0, 1'b0, AW,                  1'b0, NONE, 1'b0, NONE);  // cma
        add(5'd4,  5'd3,  1'b0, 1'b0, CWR,                 1'b0, NONE, 1'b0, NONE);  // stc
        add(5'd16, 5'd0,  1'b1, 1'b0, NONE,                1'b0, NONE, 1'b0, NONE);  // jnz z=1
        add(5'd16, 5'd0,  1'b0, 1'b0, PCW | PC_BR,         1'b0, NONE, 1'b0, NONE);  // jnz z=0
        add(5'd17, 5'd0,  1'b1, 1'b0, PCW | PC_BR,         1'b0, NONE, 1'b0, NONE);  // jnc cy=0
        add(5'd17, 5'd0,  1'b0, 1'b1, NONE,                1'b0, NONE, 1'b0, NONE);  // jnc cy=1
        add(5'd15, 5'd0,  1'b0, 1'b0, PCW | PC_BR,         1'b0, NONE, 1'b0, NONE);  // jmp
        add(5'd18, 5'd0,  1'b0, 1'b0, PCW | PC_BR | RW,    1'b0, NONE, 1'b0, NONE);  // call
        add(5'd4,  5'd13, 1'b0, 1'b0, PCW | PC_RET,        1'b0, NONE, 1'b0, NONE);  // ret
        add(5'd4,  5'd0,  1'b0, 1'b0, NONE,                1'b0, NONE, 1'b0, NONE);  // nop
        add(5'd25, 5'd0,  1'b0, 1'b0, AW,                  1'b0, NONE, 1'b0, NONE);  // mvi a
        add(5'd19, 5'd0,  1'b0, 1'b0, RW,                  1'b0, NONE, 1'b0, NONE);  // mov r,r
        add(5'd13, 5'd0,  1'b0, 1'b0, IORD, 1'b1, IORD | RD, 1'b1, AW);              // lda
        add(5'd14, 5'd0,  1'b0, 1'b0, IORD, 1'b1, IORD | WR, 1'b0, NONE);            // sta
        add(5'd23, 5'd0,  1'b0, 1'b0, IORD, 1'b1, IORD | RD, 1'b1, RW);              // mov r,m
        add(5'd2,  5'd3,  1'b0, 1'b0, IORD, 1'b1, IORD | RD, 1'b1, AW | CWR | ZW | CIN); // sbb m
        add(5'd2,  5'd9,  1'b0, 1'b0, IORD, 1'b1, IORD | RD, 1'b1, CWR | ZW);        // cmp m

        // Reset state: outputs at reset values while rst is high, then FETCH
        do_reset(); chk("reset_hold", NONE);
        step(1'b0); chk("reset_fetch", RD);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Unknown opcode: DECODE goes straight back to FETCH with no enables
        fetch_op("unk", 5'd3, 5'd0, 1'b0, 1'b0);
        step(1'b0); chk("unk_decode", NONE);
        step(1'b0); chk("unk_back_fetch", RD);

        // Reset during MEM of sta: write drops at once, FETCH follows
        fetch_op("t1", 5'd14, 5'd0, 1'b0, 1'b0);
        step(1'b0); chk("t1_decode", NONE);
        step(1'b0); chk("t1_exec", IORD);
        step(1'b0); chk("t1_mem", IORD | WR);
        do_reset(); chk("t1_rst_drop", NONE);
        do_reset(); chk("t1_rst_hold", NONE);
        step(1'b0); chk("t1_fetch", RD);

        // lda with mem_ready arriving on the third MEM cycle: 7 cycles total
        fetch_op("t4", 5'd13, 5'd0, 1'b0, 1'b0);
        step(1'b0); chk("t4_decode", NONE);
        step(1'b0); chk("t4_exec", IORD);
        step(1'b0); chk("t4_mem1", IORD | RD);
        step(1'b0); chk("t4_mem2", IORD | RD);
        step(1'b1); chk("t4_mem3", IORD | RD);
        step(1'b0); chk("t4_wb", AW);
        step(1'b0); chk("t4_next_fetch", RD);

        // 14 unanswered FETCH cycles then ready: no timeout
        do_reset();
        bus.opcode = 5'd4; bus.funct = 5'd0;
        for (int i = 0; i < 14; i++) begin
            step(1'b0); chk($sformatf("edge_wait%0d", i), RD);
        end
        step(1'b1); chk("edge_fetch_ok", IRW | RD | PCW);
        step(1'b0); chk("edge_decode", NONE);
        step(1'b0); chk("edge_exec", NONE);
        step(1'b0); chk("edge_fetch", RD);

        // 15 unanswered FETCH cycles: err and HALT, held until reset
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(1'b0); chk($sformatf("t5_wait%0d", i), RD);
        end
        step(1'b1); chk("t5_halt0", HLT | ERR);
        for (int i = 0; i < 3; i++) begin
            step(1'b1); chk($sformatf("t5_halt%0d", i + 1), HLT | ERR);
        end
        do_reset(); chk("t5_rst", NONE);
        step(1'b0); chk("t5_cleared", RD);

        // hlt: DECODE -> HALT, no PC update for 20 cycles
        fetch_op("t6", 5'd4, 5'd14, 1'b0, 1'b0);
        step(1'b0); chk("t6_decode", NONE);
        for (int i = 0; i < 20; i++) begin
            step(1'b1); chk($sformatf("t6_halt%0d", i), HLT);
        end
        do_reset(); chk("t6_rst", NONE);
        step(1'b0); chk("t6_fetch", RD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
